// File: rtl/alu_operand_stage_pkg.sv
// Shared definitions for the ALU issue/writeback stage: opcodes, instruction
// field positions and FSM state encoding.
package alu_operand_stage_pkg;

    localparam int unsigned REG_AW  = 4;
    localparam int unsigned FLAGS_W = 4;

    // Opcodes in ALU mux order; CMP is handled by the stage and issued as SUB.
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_RSH  = 4'd6;
    localparam logic [3:0] OP_LSH  = 4'd7;
    localparam logic [3:0] OP_RROT = 4'd8;
    localparam logic [3:0] OP_CMP  = 4'd9;

    // Instruction fields: [15:12] op, [11:8] rd, [7:4] ra, [3:0] rb/shamt.
    localparam int unsigned OP_MSB = 15;
    localparam int unsigned OP_LSB = 12;
    localparam int unsigned RD_MSB = 11;
    localparam int unsigned RD_LSB = 8;
    localparam int unsigned RA_MSB = 7;
    localparam int unsigned RA_LSB = 4;
    localparam int unsigned RB_MSB = 3;
    localparam int unsigned RB_LSB = 0;

    typedef enum logic {
        StIdle = 1'b0,
        StExec = 1'b1
    } state_e;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op >= OP_RSH) && (op <= OP_RROT);
    endfunction

    function automatic logic is_legal_op(input logic [3:0] op);
        return op <= OP_CMP;
    endfunction

endpackage

// File: rtl/reg_file_16x16.sv
// 16x16 register file: two async operand read ports, one async debug read
// port, one synchronous write port, asynchronous clear.
module reg_file_16x16
    import alu_operand_stage_pkg::*;
#(
    parameter int unsigned Width = 16,
    parameter int unsigned Depth = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [Width-1:0]  wdata_i,
    input  logic [REG_AW-1:0] raddr_a_i,
    output logic [Width-1:0]  rdata_a_o,
    input  logic [REG_AW-1:0] raddr_b_i,
    output logic [Width-1:0]  rdata_b_o,
    input  logic [REG_AW-1:0] dbg_addr_i,
    output logic [Width-1:0]  dbg_data_o
);

    logic [Width-1:0] mem_q [Depth];

    // Storage: cleared on reset, single write per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Reads return pre-edge contents, giving read-before-write on a same-cycle write.
    assign rdata_a_o  = mem_q[raddr_a_i];
    assign rdata_b_o  = mem_q[raddr_b_i];
    assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_operand_stage.sv
// Issue/writeback stage around a combinational ALU: accepts one instruction,
// registers its operands, drives the ALU for one cycle, then writes back.
module alu_operand_stage
    import alu_operand_stage_pkg::*;
#(
    parameter int unsigned LEN   = 16,
    parameter int unsigned NREGS = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [15:0]        in_instr,
    input  logic               ld_en,
    input  logic [REG_AW-1:0]  ld_addr,
    input  logic [LEN-1:0]     ld_data,
    input  logic [REG_AW-1:0]  dbg_addr,
    output logic [LEN-1:0]     dbg_data,
    output logic [LEN-1:0]     alu_r2,
    output logic [LEN-1:0]     alu_r3,
    output logic [3:0]         alu_opcode,
    output logic [3:0]         alu_shift,
    output logic               alu_execute,
    input  logic [LEN-1:0]     alu_r1,
    input  logic [FLAGS_W-1:0] alu_flags,
    output logic [FLAGS_W-1:0] flags_q,
    output logic               done,
    output logic               illegal
);

    state_e            state_q, state_d;
    logic              ready_q;
    logic [LEN-1:0]    alu_r2_q, alu_r3_q;
    logic [3:0]        op_q, alu_opcode_q, shift_q;
    logic [REG_AW-1:0] rd_q;
    logic              done_q, illegal_q;

    logic [3:0]        instr_op;
    logic [REG_AW-1:0] instr_rd, instr_ra, instr_rb;
    logic              accept, op_legal, op_shift, issue;
    logic              ld_fire, wb_en, rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [LEN-1:0]    rf_wdata, rf_rdata_a, rf_rdata_b;

    assign instr_op = in_instr[OP_MSB:OP_LSB];
    assign instr_rd = in_instr[RD_MSB:RD_LSB];
    assign instr_ra = in_instr[RA_MSB:RA_LSB];
    assign instr_rb = in_instr[RB_MSB:RB_LSB];

    assign accept   = in_valid && ready_q;
    assign op_legal = is_legal_op(instr_op);
    assign op_shift = is_shift_op(instr_op);
    assign issue    = accept && op_legal;

    // Loads and writebacks never collide: loads only in IDLE, writeback only in EXEC.
    assign ld_fire  = ld_en && (state_q == StIdle);
    assign wb_en    = (state_q == StExec) && (op_q != OP_CMP);
    assign rf_we    = ld_fire || wb_en;
    assign rf_waddr = wb_en ? rd_q : ld_addr;
    assign rf_wdata = wb_en ? alu_r1 : ld_data;

    reg_file_16x16 #(
        .Width (LEN),
        .Depth (NREGS)
    ) u_reg_file (
        .clk        (clk),
        .rst        (rst),
        .we_i       (rf_we),
        .waddr_i    (rf_waddr),
        .wdata_i    (rf_wdata),
        .raddr_a_i  (instr_ra),
        .rdata_a_o  (rf_rdata_a),
        .raddr_b_i  (instr_rb),
        .rdata_b_o  (rf_rdata_b),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data)
    );

    // Next state: one EXEC cycle per legal instruction, illegal ones stay IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (issue) state_d = StExec;
            StExec:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM and handshake/status pulses; ready is registered so it rises one edge after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ready_q   <= (state_d == StIdle);
            done_q    <= (state_q == StExec);
            illegal_q <= accept && !op_legal;
        end
    end

    // Operand/control capture at accept; values hold until the next legal issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_r2_q     <= '0;
            alu_r3_q     <= '0;
            op_q         <= '0;
            alu_opcode_q <= '0;
            shift_q      <= '0;
            rd_q         <= '0;
        end else if (issue) begin
            alu_r2_q     <= rf_rdata_a;
            alu_r3_q     <= op_shift ? '0 : rf_rdata_b;
            op_q         <= instr_op;
            alu_opcode_q <= (instr_op == OP_CMP) ? OP_SUB : instr_op;
            shift_q      <= op_shift ? instr_rb : 4'd0;
            rd_q         <= instr_rd;
        end
    end

    // Architectural flags: every legal op (including CMP) updates them at the end of EXEC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= '0;
        end else if (state_q == StExec) begin
            flags_q <= alu_flags;
        end
    end

    assign in_ready    = ready_q;
    assign alu_execute = (state_q == StExec);
    assign alu_r2      = alu_r2_q;
    assign alu_r3      = alu_r3_q;
    assign alu_opcode  = alu_opcode_q;
    assign alu_shift   = shift_q;
    assign done        = done_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: acts as the ALU, keeps a register/flag model
// and checks every issued instruction.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic        ld_en;
    logic [3:0]  ld_addr;
    logic [15:0] ld_data;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;
    logic [15:0] alu_r2, alu_r3, alu_r1;
    logic [3:0]  alu_opcode, alu_shift, alu_flags, flags_q;
    logic        alu_execute, done, illegal;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] m_regs [16];
    logic [3:0]  m_flags;

    always #5 clk = ~clk;

    alu_operand_stage #(
        .LEN   (16),
        .NREGS (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data),
        .alu_r2      (alu_r2),
        .alu_r3      (alu_r3),
        .alu_opcode  (alu_opcode),
        .alu_shift   (alu_shift),
        .alu_execute (alu_execute),
        .alu_r1      (alu_r1),
        .alu_flags   (alu_flags),
        .flags_q     (flags_q),
        .done        (done),
        .illegal     (illegal)
    );

    // ALU semantics: ADD SUB MUL OR AND XOR RSH LSH RROT, truncated to 16 bits.
    function automatic logic [15:0] ref_result(input logic [3:0] op, input logic [15:0] a,
                                               input logic [15:0] b, input logic [3:0] sh);
        logic [31:0] dbl;
        dbl = {a, a} >> sh;
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a * b;
            4'd3:    return a | b;
            4'd4:    return a & b;
            4'd5:    return a ^ b;
            4'd6:    return a >> sh;
            4'd7:    return a << sh;
            4'd8:    return dbl[15:0];
            default: return 16'd0;
        endcase
    endfunction

    // Flags: {zero, negative, carry/borrow, parity}.
    function automatic logic [3:0] ref_flags(input logic [3:0] op, input logic [15:0] a,
                                             input logic [15:0] b, input logic [3:0] sh);
        logic [15:0] r;
        logic [16:0] s;
        logic        c;
        r = ref_result(op, a, b, sh);
        s = {1'b0, a} + {1'b0, b};
        c = 1'b0;
        if (op == 4'd0) c = s[16];
        else if (op == 4'd1) c = (a < b);
        return {(r == 16'd0), r[15], c, ^r};
    endfunction

    // Bench-side ALU; outputs are zero unless the stage executes.
    assign alu_r1    = alu_execute ? ref_result(alu_opcode, alu_r2, alu_r3, alu_shift) : 16'd0;
    assign alu_flags = alu_execute ? ref_flags(alu_opcode, alu_r2, alu_r3, alu_shift) : 4'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic read_dbg(input logic [3:0] a, output logic [15:0] d);
        dbg_addr = a;
        #1;
        d = dbg_data;
    endtask

    task automatic check_all_regs(input string name);
        logic [15:0] d;
        for (int i = 0; i < 16; i++) begin
            read_dbg(4'(i), d);
            check($sformatf("%s r%0d", name, i), {16'd0, d}, {16'd0, m_regs[i]});
        end
        @(negedge clk);
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("in_ready wait", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic load(input logic [3:0] a, input logic [15:0] v);
        wait_ready();
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = v;
        @(negedge clk);
        ld_en     = 1'b0;
        m_regs[a] = v;
    endtask

    // ld_mode: 0 none, 1 load in the accept cycle, 2 load attempted during EXEC.
    task automatic run_instr(input logic [15:0] instr, input int ld_mode, input logic [3:0] la,
                             input logic [15:0] ldv);
        logic [3:0]  op, rd, ra, rb, eop, esh, efl;
        logic        legal, shf;
        logic [15:0] a, b, res, d;
        op    = instr[15:12];
        rd    = instr[11:8];
        ra    = instr[7:4];
        rb    = instr[3:0];
        legal = (op <= 4'd9);
        shf   = (op >= 4'd6) && (op <= 4'd8);
        wait_ready();
        a   = m_regs[ra];
        b   = shf ? 16'd0 : m_regs[rb];
        eop = (op == 4'd9) ? 4'd1 : op;
        esh = shf ? rb : 4'd0;
        res = ref_result(eop, a, b, esh);
        efl = ref_flags(eop, a, b, esh);
        in_valid = 1'b1;
        in_instr = instr;
        if (ld_mode == 1) begin
            ld_en   = 1'b1;
            ld_addr = la;
            ld_data = ldv;
        end
        @(negedge clk);
        in_valid = 1'b0;
        ld_en    = 1'b0;
        if (ld_mode == 1) m_regs[la] = ldv;
        if (legal) begin
            check("exec high", {31'd0, alu_execute}, 32'd1);
            check("ready low in exec", {31'd0, in_ready}, 32'd0);
            check("done low in exec", {31'd0, done}, 32'd0);
            check("alu_r2", {16'd0, alu_r2}, {16'd0, a});
            check("alu_r3", {16'd0, alu_r3}, {16'd0, b});
            check("alu_opcode", {28'd0, alu_opcode}, {28'd0, eop});
            check("alu_shift", {28'd0, alu_shift}, {28'd0, esh});
            read_dbg(rd, d);
            check("dbg old value in exec", {16'd0, d}, {16'd0, m_regs[rd]});
            if (ld_mode == 2) begin
                ld_en   = 1'b1;
                ld_addr = la;
                ld_data = ldv;
            end
            @(negedge clk);
            ld_en = 1'b0;
            if (op != 4'd9) m_regs[rd] = res;
            m_flags = efl;
            check("exec low after", {31'd0, alu_execute}, 32'd0);
            check("done pulse", {31'd0, done}, 32'd1);
            check("ready after exec", {31'd0, in_ready}, 32'd1);
            check("illegal low", {31'd0, illegal}, 32'd0);
            check("flags_q", {28'd0, flags_q}, {28'd0, m_flags});
            read_dbg(rd, d);
            check("writeback", {16'd0, d}, {16'd0, m_regs[rd]});
            if (ld_mode == 2) begin
                read_dbg(la, d);
                check("load in exec ignored", {16'd0, d}, {16'd0, m_regs[la]});
            end
        end else begin
            check("illegal pulse", {31'd0, illegal}, 32'd1);
            check("no exec on illegal", {31'd0, alu_execute}, 32'd0);
            check("ready after illegal", {31'd0, in_ready}, 32'd1);
            @(negedge clk);
            check("illegal one cycle", {31'd0, illegal}, 32'd0);
            check("no done on illegal", {31'd0, done}, 32'd0);
            check("no exec after illegal", {31'd0, alu_execute}, 32'd0);
            check("flags kept on illegal", {28'd0, flags_q}, {28'd0, m_flags});
        end
    endtask

    typedef struct {
        logic [15:0] instr;
        int          ld_mode;
        logic [3:0]  la;
        logic [15:0] ldv;
        logic [3:0]  chk;
        logic [15:0] exp;
    } vec_t;

    vec_t        vecs [8];
    logic [15:0] d;
    logic [15:0] rins;
    int          rmode;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Directed sequence starting from r1=5, r2=3; each row checks one register after it.
        vecs[0] = '{16'h0312, 0, 4'd0, 16'h0000, 4'd3, 16'h0008}; // ADD r3=r1+r2
        vecs[1] = '{16'h0312, 0, 4'd0, 16'h0000, 4'd3, 16'h0008}; // repeat, back-to-back
        vecs[2] = '{16'h7434, 0, 4'd0, 16'h0000, 4'd4, 16'h0080}; // LSH r4=r3<<4 (RAW)
        vecs[3] = '{16'h0512, 1, 4'd1, 16'h0100, 4'd5, 16'h0008}; // load r1 same cycle: old r1
        vecs[4] = '{16'h0612, 1, 4'd6, 16'hBEEF, 4'd6, 16'h0103}; // rd==ld_addr: writeback wins
        vecs[5] = '{16'h3123, 2, 4'd9, 16'h1234, 4'd1, 16'h000B}; // OR, load in EXEC ignored
        vecs[6] = '{16'h8436, 0, 4'd0, 16'h0000, 4'd4, 16'h2000}; // RROT 0x0008 by 6
        vecs[7] = '{16'h2545, 0, 4'd0, 16'h0000, 4'd5, 16'h0000}; // MUL truncated to 16 bits

        rst      = 1'b1;
        in_valid = 1'b0;
        in_instr = 16'h0000;
        ld_en    = 1'b0;
        ld_addr  = 4'd0;
        ld_data  = 16'h0000;
        dbg_addr = 4'd0;
        for (int i = 0; i < 16; i++) m_regs[i] = 16'h0000;
        m_flags = 4'd0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset in_ready", {31'd0, in_ready}, 32'd0);
        check("reset alu_execute", {31'd0, alu_execute}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset illegal", {31'd0, illegal}, 32'd0);
        check("reset alu_r2", {16'd0, alu_r2}, 32'd0);
        check("reset alu_r3", {16'd0, alu_r3}, 32'd0);
        check("reset alu_opcode", {28'd0, alu_opcode}, 32'd0);
        check("reset alu_shift", {28'd0, alu_shift}, 32'd0);
        check("reset flags_q", {28'd0, flags_q}, 32'd0);
        check_all_regs("reset");
        rst = 1'b0;
        #1;
        check("ready before first edge", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check("ready after first edge", {31'd0, in_ready}, 32'd1);

        // Directed table
        load(4'd1, 16'h0005);
        load(4'd2, 16'h0003);
        for (int i = 0; i < 8; i++) begin
            run_instr(vecs[i].instr, vecs[i].ld_mode, vecs[i].la, vecs[i].ldv);
            read_dbg(vecs[i].chk, d);
            check($sformatf("vec%0d r%0d", i, vecs[i].chk), {16'd0, d}, {16'd0, vecs[i].exp});
        end
        check_all_regs("after table");

        // CMP: flags only
        load(4'd1, 16'h0007);
        load(4'd2, 16'h0007);
        run_instr(16'h9012, 0, 4'd0, 16'h0000);
        check("cmp zero flag", {31'd0, flags_q[3]}, 32'd1);
        check_all_regs("after cmp");

        // Illegal op
        run_instr(16'hF123, 0, 4'd0, 16'h0000);
        check_all_regs("after illegal");

        // Reset in the middle of EXEC
        load(4'd8, 16'h0003);
        load(4'd9, 16'h0004);
        wait_ready();
        in_valid = 1'b1;
        in_instr = 16'h2A89;
        @(negedge clk);
        in_valid = 1'b0;
        check("mul exec before rst", {31'd0, alu_execute}, 32'd1);
        rst = 1'b1;
        #1;
        check("exec cleared by rst", {31'd0, alu_execute}, 32'd0);
        check("flags cleared by rst", {28'd0, flags_q}, 32'd0);
        @(negedge clk);
        check("no done after rst", {31'd0, done}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) m_regs[i] = 16'h0000;
        m_flags = 4'd0;
        read_dbg(4'd10, d);
        check("mul target after rst", {16'd0, d}, 32'd0);
        check_all_regs("after mid-exec rst");
        load(4'd1, 16'h0020);
        load(4'd2, 16'h0022);
        run_instr(16'h0B12, 0, 4'd0, 16'h0000);
        read_dbg(4'd11, d);
        check("recovery add", {16'd0, d}, 32'h0042);

        // Random instructions against the model
        for (int it = 0; it < 150; it++) begin
            rins = 16'($urandom);
            if ($urandom_range(0, 3) != 0) rins[15:12] = 4'($urandom_range(0, 9));
            rmode = int'($urandom_range(0, 2));
            if (rins[15:12] > 4'd9 && rmode == 2) rmode = 0;
            if ($urandom_range(0, 4) == 0) load(4'($urandom), 16'($urandom));
            run_instr(rins, rmode, 4'($urandom), 16'($urandom));
        end
        check_all_regs("random final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
